// File: rtl/muldiv_if.sv
// Handshake and write-port bundle between the register file side and muldiv_unit.
// The master drives the request and operands; the slave (the unit) returns status and the write port.
interface muldiv_if;
    logic        start;
    logic [1:0]  op;
    logic [15:0] operand_a;
    logic [15:0] operand_b;
    logic [2:0]  dest;
    logic        busy;
    logic        done;
    logic [15:0] bus_w;
    logic [2:0]  addr_w;
    logic        en_w;

    modport master (
        output start, op, operand_a, operand_b, dest,
        input  busy, done, bus_w, addr_w, en_w
    );

    modport slave (
        input  start, op, operand_a, operand_b, dest,
        output busy, done, bus_w, addr_w, en_w
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative 16-bit unsigned multiply/divide unit: 16 shift-add or restoring-divide
// steps, then a single registered write-port cycle.
module muldiv_unit (
    input  logic     clk,
    input  logic     reset,
    muldiv_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  count_q, count_d;
    logic [1:0]  op_q, op_d;
    logic [2:0]  dest_q, dest_d;
    logic [15:0] addend_q, addend_d;
    logic [15:0] acc_hi_q, acc_hi_d;
    logic [15:0] acc_lo_q, acc_lo_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        en_w_q, en_w_d;
    logic [15:0] bus_w_q, bus_w_d;
    logic [2:0]  addr_w_q, addr_w_d;

    logic [16:0] mul_sum;
    logic [15:0] mul_hi;
    logic [15:0] mul_lo;
    logic [16:0] div_shift;
    logic        div_ge;
    logic [15:0] div_rem;
    logic [15:0] div_quo;
    logic [15:0] step_hi;
    logic [15:0] step_lo;
    logic [15:0] result;

    // addend_q is the multiplicand for MUL and the divisor for DIV; acc_lo_q starts as
    // the multiplier (consumed LSB-first) or the dividend (consumed MSB-first).
    always_comb begin
        mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, addend_q} : 17'd0);
        mul_hi    = mul_sum[16:1];
        mul_lo    = {mul_sum[0], acc_lo_q[15:1]};

        div_shift = {acc_hi_q, acc_lo_q[15]};
        div_ge    = (div_shift >= {1'b0, addend_q});
        // The true difference is below the divisor, so 16-bit wrap-around subtraction is exact.
        div_rem   = div_ge ? (div_shift[15:0] - addend_q) : div_shift[15:0];
        div_quo   = {acc_lo_q[14:0], div_ge};

        step_hi   = op_q[1] ? div_rem : mul_hi;
        step_lo   = op_q[1] ? div_quo : mul_lo;

        case (op_q)
            2'b00:   result = mul_lo;
            2'b01:   result = mul_hi;
            2'b10:   result = div_quo;
            default: result = div_rem;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        op_d     = op_q;
        dest_d   = dest_q;
        addend_d = addend_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        en_w_d   = 1'b0;
        bus_w_d  = 16'h0000;
        addr_w_d = 3'd0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    op_d     = bus.op;
                    dest_d   = bus.dest;
                    addend_d = bus.op[1] ? bus.operand_b : bus.operand_a;
                    acc_lo_d = bus.op[1] ? bus.operand_a : bus.operand_b;
                    acc_hi_d = 16'h0000;
                    count_d  = 4'd0;
                    busy_d   = 1'b1;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                acc_hi_d = step_hi;
                acc_lo_d = step_lo;
                count_d  = count_q + 4'd1;
                // The last step's result goes straight into the output register.
                if (count_q == 4'd15) begin
                    state_d  = S_WRITE;
                    en_w_d   = 1'b1;
                    done_d   = 1'b1;
                    bus_w_d  = result;
                    addr_w_d = dest_q;
                end
            end
            S_WRITE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            count_q  <= 4'd0;
            op_q     <= 2'b00;
            dest_q   <= 3'd0;
            addend_q <= 16'h0000;
            acc_hi_q <= 16'h0000;
            acc_lo_q <= 16'h0000;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            en_w_q   <= 1'b0;
            bus_w_q  <= 16'h0000;
            addr_w_q <= 3'd0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            op_q     <= op_d;
            dest_q   <= dest_d;
            addend_q <= addend_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            en_w_q   <= en_w_d;
            bus_w_q  <= bus_w_d;
            addr_w_q <= addr_w_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.en_w   = en_w_q;
    assign bus.bus_w  = bus_w_q;
    assign bus.addr_w = addr_w_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized and directed bench for muldiv_unit, checked every cycle against an
// arithmetic reference model of the operation timeline.
module tb_muldiv_unit;

    logic clk = 1'b0;
    logic rst_n;

    muldiv_if mif ();

    muldiv_unit dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (mif)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int wr_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_result(input logic [15:0] a, input logic [15:0] b,
                                               input logic [1:0] op);
        logic [31:0] p;
        p = 32'(a) * 32'(b);
        case (op)
            2'b00:   return p[15:0];
            2'b01:   return p[31:16];
            2'b10:   return (b == 16'd0) ? 16'hFFFF : a / b;
            default: return (b == 16'd0) ? a : a % b;
        endcase
    endfunction

    // Reference model: an operation is a timeline of edges counted from its accept edge.
    bit          m_idle = 1'b1;
    int          m_cnt  = 0;
    logic [15:0] m_res  = 16'h0;
    logic [2:0]  m_dest = 3'd0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_idle <= 1'b1;
            m_cnt  <= 0;
        end else if (m_idle) begin
            if (mif.start) begin
                m_idle <= 1'b0;
                m_cnt  <= 0;
                m_res  <= ref_result(mif.operand_a, mif.operand_b, mif.op);
                m_dest <= mif.dest;
            end
        end else begin
            m_cnt <= m_cnt + 1;
            if (m_cnt == 16) m_idle <= 1'b1;
        end
    end

    always @(negedge clk) begin
        logic exp_en;
        cyc++;
        exp_en = !m_idle && (m_cnt == 16);
        check("busy",   32'(mif.busy),   32'(!m_idle));
        check("en_w",   32'(mif.en_w),   32'(exp_en));
        check("done",   32'(mif.done),   32'(exp_en));
        check("bus_w",  32'(mif.bus_w),  exp_en ? 32'(m_res) : 32'd0);
        check("addr_w", 32'(mif.addr_w), exp_en ? 32'(m_dest) : 32'd0);
        if (mif.en_w) wr_q.push_back(cyc);
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (mif.busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 32'(mif.busy), 32'd0);
    endtask

    task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op,
                         input logic [2:0] dest);
        mif.operand_a = a;
        mif.operand_b = b;
        mif.op        = op;
        mif.dest      = dest;
    endtask

    task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                          input logic [1:0] op, input logic [2:0] dest, input logic [15:0] exp);
        int lat = 0;
        wait_idle();
        drive(a, b, op, dest);
        mif.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mif.start = 1'b0;
        drive($urandom, $urandom, 2'($urandom), 3'($urandom));
        // Write cycle follows the 16th edge after the accepting edge (17th cycle from accept).
        while (!mif.en_w && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({name, "_lat"},  32'(lat + 1), 32'd17);
        check(name,            32'(mif.bus_w), 32'(exp));
        check({name, "_addr"}, 32'(mif.addr_w), 32'(dest));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        mif.start = 1'b0;
        drive(16'h0, 16'h0, 2'b00, 3'd0);
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy",   32'(mif.busy),   32'd0);
        check("rst_en_w",   32'(mif.en_w),   32'd0);
        check("rst_done",   32'(mif.done),   32'd0);
        check("rst_bus_w",  32'(mif.bus_w),  32'd0);
        check("rst_addr_w", 32'(mif.addr_w), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("mul_lo",    16'h1234, 16'h0100, 2'b00, 3'd3, 16'h3400);
        run_op("mul_hi",    16'h1234, 16'h0100, 2'b01, 3'd3, 16'h0012);
        run_op("mul_ff_lo", 16'hFFFF, 16'hFFFF, 2'b00, 3'd5, 16'h0001);
        run_op("mul_ff_hi", 16'hFFFF, 16'hFFFF, 2'b01, 3'd6, 16'hFFFE);
        run_op("mul_z_lo",  16'h0000, 16'hABCD, 2'b00, 3'd1, 16'h0000);
        run_op("mul_z_hi",  16'h0000, 16'hABCD, 2'b01, 3'd2, 16'h0000);
        run_op("div_q",     16'h03E8, 16'h0007, 2'b10, 3'd4, 16'h008E);
        run_op("div_r",     16'h03E8, 16'h0007, 2'b11, 3'd7, 16'h0006);
        run_op("div_sm_q",  16'h0005, 16'h0009, 2'b10, 3'd2, 16'h0000);
        run_op("div_sm_r",  16'h0005, 16'h0009, 2'b11, 3'd2, 16'h0005);
        run_op("div0_q",    16'h1234, 16'h0000, 2'b10, 3'd1, 16'hFFFF);
        run_op("div0_r",    16'h1234, 16'h0000, 2'b11, 3'd6, 16'h1234);

        // Starts during RUN and during WRITE must be ignored.
        wait_idle();
        base = wr_q.size();
        drive(16'h0050, 16'h0003, 2'b00, 3'd1);
        mif.start = 1'b1;
        @(negedge clk);
        mif.start = 1'b0;
        repeat (5) @(negedge clk);
        drive(16'h7777, 16'h0002, 2'b10, 3'd5);
        mif.start = 1'b1;
        @(negedge clk);
        mif.start = 1'b0;
        for (int i = 0; i < 40 && !mif.en_w; i++) @(negedge clk);
        check("busy_res",  32'(mif.bus_w),  32'h00F0);
        check("busy_addr", 32'(mif.addr_w), 32'd1);
        drive(16'h0101, 16'h0101, 2'b01, 3'd7);
        mif.start = 1'b1;
        @(negedge clk);
        mif.start = 1'b0;
        repeat (25) @(negedge clk);
        check("busy_nwrites", 32'(wr_q.size() - base), 32'd1);

        // Start held high: one write every 18 cycles.
        wait_idle();
        base = wr_q.size();
        drive(16'h1234, 16'h0003, 2'b00, 3'd2);
        mif.start = 1'b1;
        repeat (60) @(negedge clk);
        mif.start = 1'b0;
        wait_idle();
        check("held_nwrites", 32'(wr_q.size() - base), 32'd4);
        for (int i = base; i + 1 < wr_q.size(); i++)
            check("held_spacing", 32'(wr_q[i + 1] - wr_q[i]), 32'd18);

        // Reset at RUN count 8 aborts the operation.
        wait_idle();
        base = wr_q.size();
        drive(16'h4321, 16'h0011, 2'b01, 3'd3);
        mif.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mif.start = 1'b0;
        repeat (8) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy",  32'(mif.busy),  32'd0);
        check("abort_en_w",  32'(mif.en_w),  32'd0);
        check("abort_done",  32'(mif.done),  32'd0);
        check("abort_bus_w", 32'(mif.bus_w), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        check("abort_nwrites", 32'(wr_q.size() - base), 32'd0);
        run_op("post_rst", 16'h03E8, 16'h0007, 2'b10, 3'd5, 16'h008E);

        for (int i = 0; i < 40; i++) begin
            logic [15:0] a, b;
            logic [1:0]  op;
            logic [2:0]  d;
            a  = 16'($urandom);
            b  = ($urandom_range(0, 7) == 0) ? 16'd0 :
                 ($urandom_range(0, 1) == 0) ? 16'($urandom_range(1, 255)) : 16'($urandom);
            op = 2'($urandom_range(0, 3));
            d  = 3'($urandom);
            run_op("rand", a, b, op, d, ref_result(a, b, op));
        end

        wait_idle();
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
